interfaz_teclado: RTL

Keypad front-end for the ATM controller. It debounces the raw keypad, then generates the controller's input strobes: `digito`/`digito_stb` for PIN entry, and `monto`/`monto_stb` for transaction amounts. Amounts are accumulated from decimal keystrokes. The block sits between the physical keypad and the ATM controller and drives those ports directly.

---
 rtl/interfaz_teclado.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/interfaz_teclado.sv
// Keypad front-end for the ATM controller: debounces the raw keypad and turns
// accepted keys into PIN digit strobes or accumulated decimal amounts.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | no key down; waiting for the raw level to go high
// DEB_PRESS   | counting consecutive high samples of the same code
// HELD        | key accepted; waiting for the level to drop (no auto-repeat)
// DEB_RELEASE | counting consecutive low samples before re-arming
module interfaz_teclado #(
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned MAX_DIGITOS_MONTO = 9
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_tecla_presionada,
    input  logic [3:0]  i_tecla,
    input  logic        i_modo_monto,
    output logic [4:0]  o_digito,
    output logic        o_digito_stb,
    output logic [31:0] o_monto,
    output logic        o_monto_stb,
    output logic        o_tecla_invalida
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    // Down-counter holds the samples still needed; terminal count is 1.
    localparam logic [7:0] CNT_LOAD    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] NDIG_MAX    = 4'(MAX_DIGITOS_MONTO);
    localparam logic [3:0] TECLA_CLEAR = 4'd10;
    localparam logic [3:0] TECLA_ENTER = 4'd11;

    state_t      r_state;
    logic [7:0]  r_count;
    logic [3:0]  r_tecla;
    logic        r_modo_prev;
    logic [31:0] r_acum;
    logic [3:0]  r_ndig;

    logic        w_accept;
    logic        w_es_digito;
    logic        w_cambio_modo;
    logic [31:0] w_acum_base;
    logic [3:0]  w_ndig_base;
    logic [31:0] w_acum_x10;
    logic [31:0] w_acum_dig;

    always_comb begin
        w_accept      = (r_state == DEB_PRESS) && i_tecla_presionada &&
                        (i_tecla == r_tecla) && (r_count == 8'd1);
        w_es_digito   = (r_tecla <= 4'd9);
        w_cambio_modo = (i_modo_monto != r_modo_prev);
        // A mode change wipes the partial amount before the key is interpreted.
        w_acum_base   = w_cambio_modo ? 32'd0 : r_acum;
        w_ndig_base   = w_cambio_modo ? 4'd0  : r_ndig;
        w_acum_x10    = (w_acum_base << 3) + (w_acum_base << 1);
        w_acum_dig    = w_acum_x10 + {28'd0, r_tecla};
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state          <= IDLE;
            r_count          <= 8'd0;
            r_tecla          <= 4'd0;
            r_modo_prev      <= 1'b0;
            r_acum           <= 32'd0;
            r_ndig           <= 4'd0;
            o_digito         <= 5'd0;
            o_digito_stb     <= 1'b0;
            o_monto          <= 32'd0;
            o_monto_stb      <= 1'b0;
            o_tecla_invalida <= 1'b0;
        end else begin
            o_digito_stb     <= 1'b0;
            o_monto_stb      <= 1'b0;
            o_tecla_invalida <= 1'b0;
            r_modo_prev      <= i_modo_monto;
            r_acum           <= w_acum_base;
            r_ndig           <= w_ndig_base;

            case (r_state)
                IDLE: begin
                    if (i_tecla_presionada) begin
                        r_tecla <= i_tecla;
                        r_count <= CNT_LOAD;
                        r_state <= DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (!i_tecla_presionada) begin
                        r_count <= 8'd0;
                        r_state <= IDLE;
                    end else if (i_tecla != r_tecla) begin
                        r_tecla <= i_tecla;
                        r_count <= CNT_LOAD;
                    end else if (r_count == 8'd1) begin
                        r_count <= 8'd0;
                        r_state <= HELD;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                HELD: begin
                    if (!i_tecla_presionada) begin
                        r_count <= CNT_LOAD;
                        r_state <= DEB_RELEASE;
                    end
                end
                DEB_RELEASE: begin
                    if (i_tecla_presionada) begin
                        r_count <= 8'd0;
                        r_state <= HELD;
                    end else if (r_count == 8'd1) begin
                        r_count <= 8'd0;
                        r_state <= IDLE;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                default: begin
                    r_count <= 8'd0;
                    r_state <= IDLE;
                end
            endcase

            if (w_accept) begin
                if (!i_modo_monto) begin
                    if (w_es_digito) begin
                        o_digito     <= {1'b0, r_tecla};
                        o_digito_stb <= 1'b1;
                    end else if (r_tecla > TECLA_ENTER) begin
                        o_tecla_invalida <= 1'b1;
                    end
                end else begin
                    if (w_es_digito) begin
                        if (w_ndig_base < NDIG_MAX) begin
                            r_acum <= w_acum_dig;
                            r_ndig <= w_ndig_base + 4'd1;
                        end else begin
                            o_tecla_invalida <= 1'b1;
                        end
                    end else if (r_tecla == TECLA_CLEAR) begin
                        r_acum <= 32'd0;
                        r_ndig <= 4'd0;
                    end else if (r_tecla == TECLA_ENTER) begin
                        if (w_ndig_base != 4'd0) begin
                            o_monto     <= w_acum_base;
                            o_monto_stb <= 1'b1;
                            r_acum      <= 32'd0;
                            r_ndig      <= 4'd0;
                        end else begin
                            o_tecla_invalida <= 1'b1;
                        end
                    end else begin
                        o_tecla_invalida <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
